// File: rtl/fsm_reed_tx.sv
// fsm_reed_tx: buffers RS-core output bytes in a FIFO and hands them one at a time to a UART TX, flagging frame ends
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   enc_byte   : byte from RS core, qualified by enc_valid
//   enc_valid  : one-cycle strobe for enc_byte
//   Tx_DATA    : byte presented to UART TX, held from Tx_WR until Tx_BUSY falls
//   Tx_WR      : one-cycle write pulse to UART TX
//   Tx_BUSY    : UART TX busy, rises after Tx_WR, falls at end of stop bit
//   frame_done : one-cycle pulse when the last byte of a frame completes
//   fifo_count : bytes currently buffered
//   overflow   : sticky, a byte was dropped on a full FIFO
module fsm_reed_tx #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int FRAME_LEN = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        enc_byte,
  input  logic              enc_valid,
  output logic [7:0]        Tx_DATA,
  output logic              Tx_WR,
  input  logic              Tx_BUSY,
  output logic              frame_done,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0] byte_cnt;
  logic full, push, pop, last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:      state_nx = (fifo_count != '0 && !Tx_BUSY) ? SEND : IDLE;
      SEND:      state_nx = WAIT_ACK;
      WAIT_ACK:  state_nx = Tx_BUSY ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: state_nx = Tx_BUSY ? WAIT_DONE : DONE;
      default:   state_nx = IDLE;
    endcase
  end
  assign full = fifo_count == (ADDR_W+1)'(DEPTH);
  assign pop = state == IDLE && state_nx == SEND;
  // a pop in the same cycle frees a slot, so a full FIFO still accepts the byte
  assign push = enc_valid && (!full || pop);
  assign last = byte_cnt == 8'(FRAME_LEN - 1);
  assign Tx_WR = state == SEND;
  assign frame_done = state == DONE && last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      Tx_DATA <= 8'h00;
      byte_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        Tx_DATA <= mem[rd_ptr];
      end
      fifo_count <= fifo_count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      if (enc_valid && !push) overflow <= 1'b1;
      if (state == DONE) byte_cnt <= last ? '0 : byte_cnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= enc_byte;
endmodule

// File: tb/tb_fsm_reed_tx.sv
// tb_fsm_reed_tx: randomized and directed scoreboard bench for fsm_reed_tx with a behavioural UART model
module tb_fsm_reed_tx;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int FL = 4;
  logic clk = 0, reset = 0, enc_valid = 0, hold = 0, ubusy = 0;
  logic [7:0] enc_byte = 0;
  logic Tx_BUSY, Tx_WR, frame_done, overflow;
  logic [7:0] Tx_DATA;
  logic [AW:0] fifo_count;
  int checks = 0, errors = 0, cyc = 0, rem = 0, busy_len = 10;
  int sent = 0, done_cnt = 0, fd_cnt = 0, maxc = 0, lat_edge = 0;
  bit rand_len = 0, lat_chk = 0, outstanding = 0, prev_busy = 0;
  logic [7:0] last_data = 0;
  logic [7:0] exp_q[$];
  assign Tx_BUSY = hold | ubusy;
  fsm_reed_tx #(.DEPTH(DEPTH), .ADDR_W(AW), .FRAME_LEN(FL)) dut (
    .clk(clk), .reset(reset), .enc_byte(enc_byte), .enc_valid(enc_valid),
    .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_BUSY(Tx_BUSY), .frame_done(frame_done),
    .fifo_count(fifo_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  // UART model: busy for a fixed or random number of cycles after each write pulse
  always @(negedge clk) begin
    if (!reset) rem = 0;
    else if (Tx_WR) rem = rand_len ? int'($urandom_range(2, 8)) : busy_len;
    else if (rem > 0) rem--;
    ubusy = rem > 0;
  end
  // monitor: pops expected bytes on each write pulse, predicts frame_done from completed-byte count
  always @(posedge clk) begin
    bit comp;
    cyc++;
    #1;
    if (!reset) begin
      outstanding = 0;
      prev_busy = 0;
      done_cnt = 0;
    end else begin
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      comp = outstanding && prev_busy && !Tx_BUSY;
      chk("frame_done", frame_done, (comp && done_cnt % FL == FL - 1) ? 1 : 0);
      if (frame_done) fd_cnt++;
      if (outstanding) chk("tx_hold", Tx_DATA, last_data);
      if (comp) begin
        done_cnt++;
        outstanding = 0;
      end
      if (Tx_WR) begin
        chk("wr_while_busy", Tx_BUSY, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr got %h want none", Tx_DATA);
        end else chk("tx_data", Tx_DATA, exp_q.pop_front());
        if (lat_chk) begin
          chk("latency", cyc, lat_edge);
          lat_chk = 0;
        end
        last_data = Tx_DATA;
        sent++;
        outstanding = 1;
      end
      prev_busy = Tx_BUSY;
    end
  end
  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    hold = 0;
    enc_valid = 0;
    lat_chk = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1;
    maxc = 0;
  endtask
  task automatic drain();
    int run = 0;
    for (int i = 0; i < 3000 && run < 4; i++) begin
      @(posedge clk);
      #2;
      run = (exp_q.size() == 0 && !Tx_BUSY && fifo_count == 0) ? run + 1 : 0;
    end
    if (run < 4) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout queued %0d want 0", exp_q.size());
    end
  endtask
  task automatic fill(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enc_byte = 8'(first + i);
      enc_valid = 1;
      if (i < DEPTH) exp_q.push_back(8'(first + i));
    end
    @(negedge clk);
    enc_valid = 0;
  endtask
  initial begin
    int s0, f0, n;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr", Tx_WR, 0);
    chk("rst_data", Tx_DATA, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fd", frame_done, 0);
    @(negedge clk);
    reset = 1;
    // single byte
    busy_len = 10;
    s0 = sent;
    @(negedge clk);
    enc_byte = 8'hA5;
    enc_valid = 1;
    exp_q.push_back(8'hA5);
    lat_edge = cyc + 2;
    lat_chk = 1;
    @(posedge clk);
    #2 chk("single_cnt1", fifo_count, 1);
    @(negedge clk);
    enc_valid = 0;
    @(posedge clk);
    #2 chk("single_cnt0", fifo_count, 0);
    chk("single_wr", Tx_WR, 1);
    repeat (4) @(posedge clk);
    #2 chk("single_busy", Tx_BUSY, 1);
    chk("single_hold", Tx_DATA, 8'hA5);
    drain();
    chk("single_sent", sent - s0, 1);
    chk("latency_seen", lat_chk, 0);
    // burst ordering
    do_reset();
    busy_len = 20;
    s0 = sent;
    fill(5, 1);
    drain();
    chk("burst_sent", sent - s0, 5);
    chk("burst_peak", maxc, 4);
    chk("burst_ovf", overflow, 0);
    // overflow with UART held busy
    do_reset();
    busy_len = 6;
    hold = 1;
    s0 = sent;
    fill(17, 0);
    #1 chk("ovf_cnt", fifo_count, 16);
    chk("ovf_flag", overflow, 1);
    @(negedge clk);
    hold = 0;
    drain();
    chk("ovf_sent", sent - s0, 16);
    chk("ovf_sticky", overflow, 1);
    // push coinciding with pop on a full FIFO
    do_reset();
    hold = 1;
    s0 = sent;
    fill(16, 8'h20);
    #1 chk("full_cnt", fifo_count, 16);
    @(negedge clk);
    hold = 0;
    enc_byte = 8'hC3;
    enc_valid = 1;
    exp_q.push_back(8'hC3);
    @(posedge clk);
    #2 chk("pp_cnt", fifo_count, 16);
    chk("pp_ovf", overflow, 0);
    @(negedge clk);
    enc_valid = 0;
    drain();
    chk("pp_sent", sent - s0, 17);
    chk("pp_ovf_end", overflow, 0);
    // frame boundaries
    do_reset();
    busy_len = 5;
    f0 = fd_cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      enc_byte = 8'($urandom);
      enc_valid = 1;
      exp_q.push_back(enc_byte);
      @(negedge clk);
      enc_valid = 0;
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain();
    chk("frame_pulses", fd_cnt - f0, 2);
    // reset mid-transfer
    do_reset();
    busy_len = 30;
    fill(4, 8'h50);
    repeat (8) @(posedge clk);
    #2 chk("mid_busy", Tx_BUSY, 1);
    chk("mid_cnt", fifo_count, 3);
    @(negedge clk);
    reset = 0;
    exp_q.delete();
    #1;
    chk("mid_wr", Tx_WR, 0);
    chk("mid_data", Tx_DATA, 0);
    chk("mid_cnt0", fifo_count, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_fd", frame_done, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    s0 = sent;
    repeat (60) @(posedge clk);
    #2 chk("mid_no_wr", sent - s0, 0);
    busy_len = 4;
    fill(1, 8'h77);
    drain();
    chk("mid_resume", sent - s0, 1);
    // randomized traffic
    do_reset();
    rand_len = 1;
    s0 = sent;
    f0 = fd_cnt;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() < DEPTH - 2 && $urandom_range(0, 1) == 1) begin
        enc_byte = 8'($urandom);
        enc_valid = 1;
        exp_q.push_back(enc_byte);
        n++;
      end else enc_valid = 0;
    end
    @(negedge clk);
    enc_valid = 0;
    drain();
    rand_len = 0;
    chk("rand_sent", sent - s0, n);
    chk("rand_ovf", overflow, 0);
    chk("rand_frames", fd_cnt - f0, n / FL);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsm_reed_tx.md
Name: fsm_reed_tx

Overview:
Return-path controller for the Reed-Solomon link. It accepts bytes strobed out of the RS encoder/decoder and buffers them in a small FIFO. It then hands them one at a time to the UART transmitter using a write-pulse/busy handshake, and flags codeword (frame) boundaries. It sits between the RS core output and the UART TX block, opposite the RX-side feeder FSM.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, 2..256
ADDR_W, 4, log2(DEPTH)
FRAME_LEN, 255, bytes per codeword/frame; 1..255

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
enc_byte  input  8  byte from RS core
enc_valid  input  1  one-cycle strobe: enc_byte valid this cycle
Tx_DATA  output  8  byte presented to UART TX; held stable from Tx_WR until Tx_BUSY falls
Tx_WR  output  1  one-cycle write pulse to UART TX
Tx_BUSY  input  1  UART TX busy; contract: rises the cycle after Tx_WR, falls when the stop bit is done
frame_done  output  1  one-cycle pulse when the last byte of a frame completes
fifo_count  output  ADDR_W+1  bytes currently buffered
overflow  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, async): state=IDLE; FIFO pointers, fifo_count and byte counter = 0; Tx_DATA=8'h00; Tx_WR=0; frame_done=0; overflow=0. Takes effect mid-frame and mid-transfer. Buffered bytes are discarded and no further Tx_WR is issued.
- FIFO push: enc_valid=1 and (count<DEPTH or pop in same cycle) -> write at wr_ptr, wr_ptr+1 (wraps mod DEPTH).
- Overflow: enc_valid=1, count==DEPTH, no pop this cycle -> byte dropped, overflow<=1. Overflow stays set until reset.
- Pop: occurs only on the IDLE->SEND transition. Tx_DATA<=mem[rd_ptr], rd_ptr+1 (wraps).
- Simultaneous push+pop: count unchanged; both pointers advance. Push+pop on an empty FIFO is impossible, because pop requires count>0 in the previous cycle.
- FSM states:
  IDLE: if count>0 and Tx_BUSY=0 -> SEND (pop, load Tx_DATA); else stay.
  SEND: Tx_WR=1 for exactly this cycle -> WAIT_ACK.
  WAIT_ACK: wait for Tx_BUSY=1 -> WAIT_DONE.
  WAIT_DONE: wait for Tx_BUSY=0 -> DONE.
  DONE: byte_cnt increments. If byte_cnt==FRAME_LEN-1: frame_done=1 this cycle and byte_cnt<=0. -> IDLE.
- Latency: enc_valid strobe in cycle N with an empty FIFO and an idle UART -> Tx_WR high in cycle N+2.
- Throughput: one byte per UART frame plus 3 cycles of overhead (SEND, DONE, IDLE).
- Tx_WR is never asserted while Tx_BUSY=1 or while the FIFO is empty.
- byte_cnt: 8 bits. FRAME_LEN=1 gives frame_done on every byte.
- fifo_count is registered and reflects the count after each edge.
- Encoding of unused FSM states: any unused state returns to IDLE.

Test Plan:
- Single byte: reset, then enc_byte=8'hA5 with a 1-cycle enc_valid at cycle N, UART model busy for 10 cycles -> Tx_WR high only at N+2 with Tx_DATA=A5; fifo_count 1 then 0; Tx_DATA still A5 while Tx_BUSY=1.
- Burst ordering: 5 back-to-back strobes 01..05, UART busy 20 cycles/byte -> exactly 5 Tx_WR pulses, data 01,02,03,04,05 in order; fifo_count peaks at 4; no overflow.
- Overflow: DEPTH=16, UART held busy, 17 strobes 00..10 -> fifo_count=16, overflow=1 after the 17th strobe, byte 10 never transmitted; after release, 00..0F are sent.
- Simultaneous push/pop at full: FIFO full, push coincides with the IDLE->SEND pop -> byte accepted, count stays 16, overflow stays 0.
- Frame boundary: FRAME_LEN=4, send 8 bytes -> frame_done pulses exactly twice, each in the DONE cycle after the 4th and 8th byte's Tx_BUSY fall.
- Reset mid-transfer: assert reset=0 while in WAIT_DONE with 3 bytes buffered -> outputs at reset values immediately; after release, no Tx_WR until a new enc_valid.
